port_tx_arbiter: RTL and testbench

PORT_TX_ARBITER -- requirements
Module: port_tx_arbiter

---
 rtl/port_tx_arbiter.sv | 107 ++++++++++
 tb/tb_port_tx_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/port_tx_arbiter.sv
// port_tx_arbiter
// ---------------
// Output-port arbiter for a 4-input switch. Each input FIFO presents its head
// packet (src_valid/src_data). When the single-entry output register is free,
// or is being drained this cycle, one source is chosen round-robin, popped via
// a combinational src_ready strobe and captured into the output register.
// Sustains one packet per cycle when the sink is always ready.
//
// Parameters:
//   DATA_W   payload width per packet
//   PORT_ID  index (0..3) of the output port this instance drives
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   src_valid   [3:0]  head packet of input FIFO i targets this port
//   src_data    [4*DATA_W-1:0] head payloads, slice i = [i*DATA_W +: DATA_W]
//   src_ready   [3:0]  one-hot pop strobe to the granted input FIFO (comb.)
//   valid_out          output packet valid
//   source_out  [3:0]  one-hot source of the current output packet
//   data_out    [DATA_W-1:0] current output payload
//   ready_out          sink accepts the packet when high with valid_out
//   tx_count    [15:0] packets accepted by the sink, saturating

module port_tx_arbiter #(
  parameter int DATA_W  = 8,
  parameter int PORT_ID = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          src_valid,
  input  logic [4*DATA_W-1:0] src_data,
  output logic [3:0]          src_ready,
  output logic                valid_out,
  output logic [3:0]          source_out,
  output logic [DATA_W-1:0]   data_out,
  input  logic                ready_out,
  output logic [15:0]         tx_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic        found;
  logic        slot_open;
  logic        grant_any;

  // Catch an out-of-range port index at elaboration time.
  if (PORT_ID < 0 || PORT_ID > 3) begin : g_bad_port_id
    $error("port_tx_arbiter: PORT_ID must be in 0..3");
  end

  // The output register can take a new packet when it is empty or when its
  // current packet leaves this cycle.
  assign slot_open = (state == IDLE) || ready_out;

  // Round-robin search starting at rr_ptr. Scanning offsets from high to low
  // lets the closest requester (smallest offset) overwrite the others.
  always_comb begin
    grant_idx = 2'd0;
    cand      = 2'd0;
    found     = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (src_valid[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end

  // rst_n gates the strobe so no FIFO is popped while the block is in reset.
  assign grant_any = rst_n && slot_open && found;
  assign src_ready = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  assign valid_out = (state == SEND);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 2'd0;
      source_out <= 4'b0000;
      data_out   <= '0;
      tx_count   <= 16'd0;
    end else begin
      if (valid_out && ready_out && tx_count != 16'hFFFF)
        tx_count <= tx_count + 16'd1;

      // A grant refills the register even while the old packet drains, which
      // gives back-to-back transfers; source/data only move on a grant.
      if (grant_any) begin
        state      <= SEND;
        data_out   <= src_data[int'(grant_idx)*DATA_W +: DATA_W];
        source_out <= 4'b0001 << grant_idx;
        rr_ptr     <= grant_idx + 2'd1;
      end else if (state == SEND && ready_out) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_port_tx_arbiter.sv
// tb_port_tx_arbiter
// ------------------
// Randomized and directed stimulus for port_tx_arbiter, checked every cycle
// against a transaction-level reference model (a pointer, a held packet and a
// saturating counter). Directed sequences cover basic transfer, fairness,
// backpressure, pointer wrap, reset mid-SEND and tx_count saturation.

module tb_port_tx_arbiter;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [3:0]          src_valid;
  logic [4*DATA_W-1:0] src_data;
  logic [3:0]          src_ready;
  logic                valid_out;
  logic [3:0]          source_out;
  logic [DATA_W-1:0]   data_out;
  logic                ready_out;
  logic [15:0]         tx_count;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  bit          model_known = 0;
  bit          m_valid;
  int          m_src;
  logic [7:0]  m_data;
  int          m_rr;
  int          m_count;

  logic [3:0]  seen_ready;
  logic [3:0]  held_src;
  logic [7:0]  held_data;

  always #5 clk = ~clk;

  port_tx_arbiter #(.DATA_W(DATA_W), .PORT_ID(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .valid_out  (valid_out),
    .source_out (source_out),
    .data_out   (data_out),
    .ready_out  (ready_out),
    .tx_count   (tx_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // First requester at or after ptr, wrapping; -1 when nobody requests.
  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // One clock cycle: drive inputs at the falling edge, compare everything the
  // model predicts, then advance the model on the rising edge.
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d,
                               input logic rdy, input logic rst);
    int         g;
    logic [3:0] exp_ready;
    @(negedge clk);
    src_valid = v;
    src_data  = d;
    ready_out = rdy;
    rst_n     = rst;
    #1;
    g = (rst && (!m_valid || rdy)) ? pick(v, m_rr) : -1;
    exp_ready  = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    seen_ready = src_ready;
    checkOutput("src_ready", {28'd0, src_ready}, {28'd0, exp_ready});
    if (model_known) begin
      checkOutput("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
      checkOutput("tx_count", {16'd0, tx_count}, m_count);
      if (m_valid) begin
        checkOutput("source_out", {28'd0, source_out}, {28'd0, 4'b0001 << m_src});
        checkOutput("data_out", {24'd0, data_out}, {24'd0, m_data});
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_valid     = 0;
      m_rr        = 0;
      m_count     = 0;
      model_known = 1;
    end else begin
      if (m_valid && rdy) m_count = (m_count < 65535) ? m_count + 1 : 65535;
      if (g >= 0) begin
        m_valid = 1;
        m_src   = g;
        m_data  = d[g*DATA_W +: DATA_W];
        m_rr    = (g + 1) % 4;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic doReset();
    applyStimulus(4'b0000, $urandom, 1'b0, 1'b0);
    applyStimulus(4'b1111, $urandom, 1'b1, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    rst_n     = 1'b0;
    src_valid = 4'b0000;
    src_data  = '0;
    ready_out = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("reset_source", {28'd0, source_out}, 32'd0);
    checkOutput("reset_data", {24'd0, data_out}, 32'd0);
    checkOutput("reset_count", {16'd0, tx_count}, 32'd0);

    // Basic single packet from port 2
    applyStimulus(4'b0100, 32'h11A5_2233, 1'b1, 1'b1);
    checkOutput("basic_grant", {28'd0, seen_ready}, 32'h4);
    checkOutput("basic_valid", {31'd0, valid_out}, 32'd1);
    checkOutput("basic_source", {28'd0, source_out}, 32'h4);
    checkOutput("basic_data", {24'd0, data_out}, 32'hA5);
    applyStimulus(4'b0000, $urandom, 1'b1, 1'b1);
    checkOutput("basic_count", {16'd0, tx_count}, 32'd1);
    checkOutput("basic_idle", {31'd0, valid_out}, 32'd0);

    // Fairness: all requesting, grants rotate 0,1,2,3,...
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b1111, $urandom, 1'b1, 1'b1);
      checkOutput("fair_grant", {28'd0, seen_ready}, {28'd0, 4'b0001 << (i % 4)});
    end
    applyStimulus(4'b0000, $urandom, 1'b1, 1'b1);
    checkOutput("fair_count", {16'd0, tx_count}, 32'd8);

    // Backpressure: hold for 5 cycles, then the next grant goes same cycle
    applyStimulus(4'b0011, 32'h0000_C3D4, 1'b1, 1'b1);
    checkOutput("bp_first", {28'd0, seen_ready}, 32'h1);
    held_src  = source_out;
    held_data = data_out;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0011, $urandom, 1'b0, 1'b1);
      checkOutput("bp_no_pop", {28'd0, seen_ready}, 32'd0);
      checkOutput("bp_src_hold", {28'd0, source_out}, {28'd0, held_src});
      checkOutput("bp_data_hold", {24'd0, data_out}, {24'd0, held_data});
      checkOutput("bp_valid_hold", {31'd0, valid_out}, 32'd1);
    end
    applyStimulus(4'b0011, 32'h0000_77D4, 1'b1, 1'b1);
    checkOutput("bp_release", {28'd0, seen_ready}, 32'h2);
    checkOutput("bp_next_data", {24'd0, data_out}, 32'h77);

    // Wrap: grant port 2 -> pointer 3, port 0 only -> grant 0, pointer 1
    applyStimulus(4'b0100, $urandom, 1'b1, 1'b1);
    checkOutput("wrap_g2", {28'd0, seen_ready}, 32'h4);
    applyStimulus(4'b0001, $urandom, 1'b1, 1'b1);
    checkOutput("wrap_g0", {28'd0, seen_ready}, 32'h1);
    applyStimulus(4'b1111, $urandom, 1'b1, 1'b1);
    checkOutput("wrap_ptr1", {28'd0, seen_ready}, 32'h2);

    // Reset mid-SEND discards the held packet
    applyStimulus(4'b1000, $urandom, 1'b0, 1'b1);
    applyStimulus(4'b1111, $urandom, 1'b0, 1'b0);
    checkOutput("rst_no_pop", {28'd0, seen_ready}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("rst_count", {16'd0, tx_count}, 32'd0);
    applyStimulus(4'b1111, $urandom, 1'b1, 1'b1);
    checkOutput("rst_resume", {28'd0, seen_ready}, 32'h1);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      applyStimulus(4'($urandom), d, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 49) != 0));
    end

    // Saturation: sustained back-to-back transfers past 16'hFFFF
    doReset();
    for (int i = 0; i < 65540; i++) begin
      applyStimulus(4'b1111, $urandom, 1'b1, 1'b1);
    end
    checkOutput("sat_count", {16'd0, tx_count}, 32'hFFFF);
    applyStimulus(4'b0000, $urandom, 1'b1, 1'b1);
    checkOutput("sat_hold", {16'd0, tx_count}, 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
